// File: rtl/mips_main_ctrl.sv
// -----------------------------------------------------------------------------
// mips_main_ctrl
//
// Multi-cycle main control unit for the MIPS datapath. It walks each
// instruction through fetch, decode, execute, memory and write-back states,
// selected by the 6-bit opcode. It stalls in the memory states until
// mem_ready is seen. The 2-bit alu_op feeds the downstream alu_ctrl block.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset (forces IDLE immediately)
//   opcode[5:0]    instr[31:26] from the instruction register
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load qualified by ALU zero (beq)
//   i_or_d         memory address select: 0 = PC, 1 = ALU out
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       instruction register load
//   mem_to_reg     write-back data select: 1 = MDR, 0 = ALU out
//   reg_dst        destination register: 1 = rd, 0 = rt
//   reg_write      register file write
//   alu_src_a      ALU A select: 0 = PC, 1 = reg A
//   alu_src_b[1:0] ALU B select: 00 B, 01 4, 10 imm, 11 imm<<2
//   alu_op[1:0]    00 add, 01 subtract, 10 use funct
//   pc_source[1:0] 00 ALU result, 01 ALU out reg, 10 jump target
//   illegal_op     unrecognised opcode seen in DECODE
//   state[3:0]     current state code (debug)
// -----------------------------------------------------------------------------
module mips_main_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every fetch cycle, but the PC and IR
                // only load in the cycle the memory delivers the word.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is computed speculatively here.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    // Opcode changed under us; abandon the instruction.
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // Codes 13-15 are unreachable; recover with all outputs off.
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_main_ctrl.sv
module tb_mips_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    mips_main_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Output vector: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
    // alu_op, pc_source, illegal_op}
    logic [16:0] obs;
    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, illegal_op};

    // Reference output table, written directly from the per-state output list.
    function automatic logic [16:0] ref_out(int st, bit rdy, bit ill);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, il;
        logic [1:0] sb, op, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, il} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            1:       begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
            2:       begin sb = 2'b11; il = ill; end
            3, 11:   begin sa = 1; sb = 2'b10; end
            4:       begin mr = 1; iod = 1; end
            5:       begin rw = 1; m2r = 1; end
            6:       begin mw = 1; iod = 1; end
            7:       begin sa = 1; op = 2'b10; end
            8:       begin rw = 1; rd = 1; end
            9:       begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            10:      begin pw = 1; ps = 2'b10; end
            12:      begin rw = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, il};
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b001000};
    endfunction

    // Runs one instruction starting from the cycle its FETCH begins. The
    // expected state path is built from the opcode's instruction class, with
    // f_stall/m_stall wait cycles inserted in FETCH and the memory state.
    task automatic run_instr(string name, logic [5:0] op, int f_stall, int m_stall,
                             output int regw_seen);
        int  sq[$];
        bit  rq[$];
        bit  ill;
        logic [16:0] exp_v;
        regw_seen = 0;
        ill = !is_legal(op);
        for (int i = 0; i < f_stall; i++) begin sq.push_back(1); rq.push_back(0); end
        sq.push_back(1); rq.push_back(1);
        sq.push_back(2); rq.push_back(1'($urandom));
        case (op)
            6'b000000: begin sq.push_back(7); rq.push_back(1'($urandom));
                             sq.push_back(8); rq.push_back(1'($urandom)); end
            6'b100011: begin
                sq.push_back(3); rq.push_back(1'($urandom));
                for (int i = 0; i < m_stall; i++) begin sq.push_back(4); rq.push_back(0); end
                sq.push_back(4); rq.push_back(1);
                sq.push_back(5); rq.push_back(1'($urandom));
            end
            6'b101011: begin
                sq.push_back(3); rq.push_back(1'($urandom));
                for (int i = 0; i < m_stall; i++) begin sq.push_back(6); rq.push_back(0); end
                sq.push_back(6); rq.push_back(1);
            end
            6'b000100: begin sq.push_back(9);  rq.push_back(1'($urandom)); end
            6'b000010: begin sq.push_back(10); rq.push_back(1'($urandom)); end
            6'b001000: begin sq.push_back(11); rq.push_back(1'($urandom));
                             sq.push_back(12); rq.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < sq.size(); i++) begin
            @(posedge clk); #1;
            opcode    = op;
            mem_ready = rq[i];
            @(negedge clk);
            exp_v = ref_out(sq[i], rq[i], ill);
            if (reg_write) regw_seen++;
            n_tests++;
            if (state !== 4'(sq[i])) begin
                n_fail++;
                $display("FAIL %s_state cyc=%0d op=%b got=%0d exp=%0d", name, i, op, state, sq[i]);
            end
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL %s_outputs cyc=%0d st=%0d rdy=%b got=%h exp=%h",
                         name, i, sq[i], rq[i], obs, exp_v);
            end
            n_tests++;
            if ((mem_read && mem_write) || (reg_write && (pc_write || mem_write)) ||
                (pc_write && mem_write)) begin
                n_fail++;
                $display("FAIL %s_exclusive cyc=%0d got=%h exp=no_overlap", name, i, obs);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = '0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (state !== 4'd0 || obs !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_idle got=%0d/%h exp=0/00000", state, obs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (state !== 4'd0 || obs !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_release_idle got=%0d/%h exp=0/00000", state, obs);
        end
    endtask

    task automatic test_rtype();
        int rw;
        run_instr("rtype", 6'b000000, 0, 0, rw);
    endtask

    task automatic test_lw_stall();
        int rw;
        run_instr("lw_stall", 6'b100011, 0, 2, rw);
    endtask

    task automatic test_sw_beq();
        int rw;
        run_instr("sw", 6'b101011, 1, 1, rw);
        n_tests++;
        if (rw !== 0) begin
            n_fail++;
            $display("FAIL sw_no_regwrite got=%0d exp=0", rw);
        end
        run_instr("beq", 6'b000100, 0, 0, rw);
    endtask

    task automatic test_j_addi();
        int rw;
        run_instr("j", 6'b000010, 0, 0, rw);
        run_instr("addi", 6'b001000, 0, 0, rw);
    endtask

    task automatic test_illegal();
        int rw;
        run_instr("illegal", 6'b111111, 0, 0, rw);
        n_tests++;
        if (rw !== 0) begin
            n_fail++;
            $display("FAIL illegal_no_regwrite got=%0d exp=0", rw);
        end
    endtask

    task automatic test_random();
        int rw;
        logic [5:0] pool [6] = '{6'b000000, 6'b100011, 6'b101011,
                                 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = pool[$urandom_range(0, 5)];
            end
            run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3), rw);
        end
    endtask

    task automatic test_async_reset();
        int rw;
        opcode = 6'b101011;
        // FETCH, DECODE, MEM_ADDR with memory ready
        repeat (3) begin
            @(posedge clk); #1; mem_ready = 1'b1;
        end
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (state !== 4'd6 || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_in_memwrite got=%0d/%b exp=6/1", state, mem_write);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd0 || mem_write !== 1'b0 || obs !== 17'h0) begin
            n_fail++;
            $display("FAIL arst_immediate got=%0d/%b/%h exp=0/0/00000", state, mem_write, obs);
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_held got=%0d exp=0", state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (state !== 4'd0 || obs !== 17'h0) begin
            n_fail++;
            $display("FAIL arst_release_idle got=%0d/%h exp=0/00000", state, obs);
        end
        run_instr("after_arst", 6'b000000, 0, 0, rw);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_beq();
        test_j_addi();
        test_illegal();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_main_ctrl.md
# mips_main_ctrl

Multi-cycle main control unit for the MIPS processor, directly upstream of `alu_ctrl`. It sequences each instruction through fetch, decode, execute, memory and write-back states from the 6-bit opcode. It produces all datapath enables, mux selects and the 2-bit `alu_op` that `alu_ctrl` consumes. It waits on a memory-ready handshake for every instruction or data access.

## Interface
- No parameters.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: `instr[31:26]` from the instruction register.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load when ALU zero is set (beq).
- `i_or_d` output 1: memory address select; 0 = PC, 1 = ALU out.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `ir_write` output 1: instruction register load.
- `mem_to_reg` output 1: write-back data select; 1 = MDR, 0 = ALU out.
- `reg_dst` output 1: destination register; 1 = rd, 0 = rt.
- `reg_write` output 1: register file write.
- `alu_src_a` output 1: ALU A select; 0 = PC, 1 = reg A.
- `alu_src_b` output 2: ALU B select; 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2.
- `alu_op` output 2: to `alu_ctrl`; 00 = add, 01 = subtract, 10 = use funct.
- `pc_source` output 2: PC select; 00 = ALU result, 01 = ALU out register, 10 = jump target.
- `illegal_op` output 1: unrecognised opcode seen in DECODE.
- `state` output 4: current state code, for debug.

## Operation
- Only the state register is clocked. All outputs are decoded combinationally from the state. In the memory states, some outputs are also qualified by `mem_ready`, as listed below.
- Any output not listed for a state is 0.
- States and codes:
  - IDLE = 0. All outputs 0. Always moves to FETCH.
  - FETCH = 1. Outputs: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH while `mem_ready`=0; moves to DECODE otherwise.
  - DECODE = 2. Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Next state by opcode:
    - 000000 (R-type) → EXECUTE
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - 001000 (addi) → ADDI_EXEC
    - any other → FETCH, with `illegal_op`=1 for this cycle.
  - MEM_ADDR = 3. Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Moves to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ = 4. Outputs: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then moves to MEM_WB.
  - MEM_WB = 5. Outputs: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Moves to FETCH.
  - MEM_WRITE = 6. Outputs: `mem_write`=1, `i_or_d`=1, held until `mem_ready`. Moves to FETCH on `mem_ready`.
  - EXECUTE = 7. Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Moves to ALU_WB.
  - ALU_WB = 8. Outputs: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Moves to FETCH.
  - BRANCH = 9. Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Moves to FETCH.
  - JUMP = 10. Outputs: `pc_write`=1, `pc_source`=10. Moves to FETCH.
  - ADDI_EXEC = 11. Outputs match MEM_ADDR. Moves to ADDI_WB.
  - ADDI_WB = 12. Outputs: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Moves to FETCH.
- Unused codes 13–15 move to FETCH, with all outputs 0.
- `opcode` is sampled only in DECODE and MEM_ADDR. It must be stable from FETCH completion until the next `ir_write`.

## Timing
- `rst_n` low forces the state to IDLE immediately, without waiting for a clock edge. With the state at IDLE, all outputs are 0.
- First FETCH occurs on the first rising edge after `rst_n` is released.
- Reset asserted mid-instruction abandons the instruction. The next write enable is only possible from FETCH after release.
- Cycles per instruction, with `mem_ready` held at 1:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- `mem_read` and `mem_write` are held constant across wait cycles. `pc_write` and `ir_write` pulse only in the completing FETCH cycle.
- `mem_read` and `mem_write` are never both 1.
- `reg_write`, `pc_write` and `mem_write` are never 1 in the same cycle, except that `pc_write` coincides with FETCH's `mem_read`.

## Test plan
- Reset then R-type:
  - Stimulus: hold `rst_n`=0, release; `mem_ready`=1, `opcode`=000000.
  - Required: outputs all 0 in IDLE; `state` = 1, 2, 7, 8, 1.
  - Required: `alu_op`=10 in EXECUTE; `reg_write`=1 and `reg_dst`=1 in ALU_WB.
- lw with a 2-cycle memory stall:
  - Stimulus: `opcode`=100011; `mem_ready`=0 for 2 cycles in MEM_READ.
  - Required: `state` = 1, 2, 3, 4, 4, 4, 5, 1; `mem_read`=1 and `i_or_d`=1 throughout MEM_READ; `mem_to_reg`=1 in MEM_WB.
- sw and beq:
  - sw (101011): MEM_WRITE asserts `mem_write`=1 only, with no `reg_write` anywhere in the instruction.
  - beq (000100): 3 cycles; `alu_op`=01, `pc_write_cond`=1, `pc_source`=01 in BRANCH.
- j and addi:
  - j (000010): `pc_write`=1 with `pc_source`=10 in JUMP.
  - addi (001000): `state` = 1, 2, 11, 12, 1; `alu_src_b`=10 in ADDI_EXEC; `reg_dst`=0 in ADDI_WB.
- Illegal opcode:
  - Stimulus: `opcode`=111111.
  - Required: `illegal_op`=1 for exactly the DECODE cycle, then FETCH; no write enable asserted.
- Asynchronous reset mid-stall:
  - Stimulus: drop `rst_n` between clock edges while in MEM_WRITE.
  - Required: `state`=0 and `mem_write`=0 immediately, before the next clock edge; FETCH follows release.
